// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending controller.
package irq_pkg;

  // Index width for N sources; never narrower than 1 bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = n - 1;
    while (v != 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: highest set bit of A wins; valid flags any set bit.
module priority_encoder
  import irq_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = clog2(N)
) (
  input  logic [N-1:0]   A,
  output logic [IDW-1:0] Y,
  output logic           valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    Y     = '0;
    valid = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (A[i]) begin
        Y     = IDW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Rising-edge interrupt latch with masking and a valid/ack presentation stage.
// Optional sticky per-source overflow flags when IRQ_OVERFLOW_EN is defined.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic           valid,
  output logic [IDW-1:0] id,
  input  logic           ack,
`ifdef IRQ_OVERFLOW_EN
  output logic [N-1:0]   ovf,
`endif
  output logic [N-1:0]   pend
);

  state_t         state;
  state_t         state_n;
  logic [N-1:0]   req_d;
  logic [N-1:0]   pending;
  logic [N-1:0]   pending_n;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr;
  logic [N-1:0]   eligible;
  logic [IDW-1:0] enc_y;
  logic           enc_valid;
  logic           valid_n;
  logic [IDW-1:0] id_n;

  assign rise     = req & ~req_d;
  assign eligible = pending & ~mask;
  // Set has priority over clear so a coincident new edge is never lost.
  assign pending_n = (pending & ~clr) | rise;
  assign pend      = pending;

  priority_encoder #(.N(N)) u_enc (
    .A     (eligible),
    .Y     (enc_y),
    .valid (enc_valid)
  );

  // Next-state and presentation logic; presented id is frozen until ack.
  always_comb begin
    state_n = state;
    valid_n = valid;
    id_n    = id;
    clr     = '0;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (enc_valid) begin
          id_n    = enc_y;
          valid_n = 1'b1;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          clr     = N'(1) << id;
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_d   <= '0;
      pending <= '0;
      valid   <= 1'b0;
      id      <= '0;
    end else begin
      state   <= state_n;
      req_d   <= req;
      pending <= pending_n;
      valid   <= valid_n;
      id      <= id_n;
    end
  end

`ifdef IRQ_OVERFLOW_EN
  logic [N-1:0] ovf_set;

  // Overflow: a new edge on a source still pending and not retiring this cycle.
  assign ovf_set = rise & pending & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
    end else begin
      ovf <= (ovf & ~clr) | ovf_set;
    end
  end
`endif

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
Latches rising-edge interrupt requests from N sources into a pending register, masks them, and feeds the eligible set to the combinational priority_encoder. The highest-index eligible source is presented to a downstream consumer with a valid/ack handshake, and its pending bit is cleared on acknowledge. The block sits directly upstream of the priority encoder and turns it into a sequential request-servicing stage.

Parameters:
N, 4, number of request sources; legal range 2..32.
IDW, clog2(N), width of id output; derived, not overridden.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  N  raw request lines, edge-detected internally; bit i is source i.
mask  input  N  1 = source blocked from selection; pending still latches.
valid  output  1  an id is being presented.
id  output  IDW  index of presented source; highest index has priority.
ack  input  1  consumer accepts the presented id; ignored when valid=0.
pend  output  N  current pending register, for debug/status.

Behaviour:
- Reset (rst=1 at a clk edge): req_d=0, pending=0, valid=0, id=0, state=IDLE. Because req_d resets to 0, a req bit already high when reset releases counts as a rising edge on the first cycle.
- Edge detect: rise = req & ~req_d; req_d <= req every cycle.
- Pending update each cycle: pending_next = (pending & ~clr) | rise. clr is one-hot of id, asserted only when state=PRESENT and ack=1.
  - If set and clear hit the same bit in the same cycle, set wins, so a new event is never lost.
- Eligible = pending & ~mask. Encoding uses priority_encoder semantics: the highest set bit wins.
- FSM states are IDLE and PRESENT.
  - IDLE: if eligible != 0, register id <= encoder Y, valid <= 1, go to PRESENT. Otherwise stay, with valid=0.
  - PRESENT: id and valid are held stable until ack. Mask changes and newly arriving higher-priority edges do not preempt or withdraw the presented id.
  - PRESENT with ack=1: clear pending[id], valid <= 0, go to IDLE.
- Latency:
  - Edge on req to pending bit set: 1 cycle.
  - Pending to valid: 1 further cycle from IDLE, so a req edge at cycle t gives valid=1 at t+2.
  - After ack, valid is low for at least 1 cycle before the next presentation.
- A pending bit for a masked source persists. It becomes eligible the cycle after mask clears.
- rst asserted mid-handshake aborts everything: valid=0 next cycle and all pending events are discarded.
- pend reflects the registered pending value (post-update, 1 cycle after the edge).

Optional Feature:
Macro: IRQ_OVERFLOW_EN.
- Defined: adds output port ovf [N-1:0]. ovf[i] is a sticky flag set when a rise on source i occurs while pending[i] is already 1 and is not being cleared that cycle. ovf[i] is cleared when source i is acked, unless a new overflow occurs in that same cycle. Reset value is 0.
- Undefined: no ovf port and no associated logic. Repeated edges on an already-pending source merge silently.

Decomposition:
- Package irq_pkg:
  - clog2 function, used for IDW.
  - state typedef enum logic {IDLE, PRESENT}.
- Sub-module: the existing priority_encoder #(N), with A=eligible, Y feeding id capture, valid used as the any-eligible flag.
- Edge detect, pending register and FSM stay in irq_pending_ctrl.

Test Plan:
- Single source: reset, then req 0000->0010 held. Required: pend=0010 one cycle later; valid=1 with id=1 at t+2; ack=1 gives pend=0000 and valid=0 next cycle.
- Priority: edges on req bits 0 and 2 in the same cycle. Required: id=2 presented first; after ack and a 1-cycle gap, id=0 is presented.
- Mask: mask=1000, edge on bit 3. Required: pend=1000 and valid stays 0. Clear mask: valid=1 with id=3 one cycle later.
- No preemption: presenting id=1, then edge on bit 3. Required: id stays 1 until ack. Next presentation is id=3.
- Set/clear collision: ack of id=2 in the same cycle as a new rise on bit 2. Required: pend[2] stays 1 and id=2 is re-presented after the gap. With IRQ_OVERFLOW_EN, a second rise on a still-pending bit 2 sets ovf[2]=1.
- Reset mid-handshake: valid=1 and pend=0110, then rst pulse. Required: valid=0, pend=0000 and id=0 the next cycle.
